traffic_phase_controller: RTL



---
 rtl/traffic_phase_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_controller
// Function : Two-way intersection phase sequencer with a latched pedestrian
//            walk phase, one-hot LED decode and remaining-seconds countdown.
// Revision : 1.0  initial release
// ============================================================================
module traffic_phase_controller #(
    parameter int GREEN_S  = 10,
    parameter int YELLOW_S = 3,
    parameter int ALLRED_S = 1,
    parameter int WALK_S   = 5,
    parameter int CNT_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1s,
    input  logic             ped_req,
    output logic [7:0]       leds,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [2:0] {
        ST_NS_GREEN  = 3'd0,
        ST_NS_YELLOW = 3'd1,
        ST_ALLRED_A  = 3'd2,
        ST_EW_GREEN  = 3'd3,
        ST_EW_YELLOW = 3'd4,
        ST_ALLRED_B  = 3'd5,
        ST_PED_WALK  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] C_GREEN  = CNT_W'(GREEN_S);
    localparam logic [CNT_W-1:0] C_YELLOW = CNT_W'(YELLOW_S);
    localparam logic [CNT_W-1:0] C_ALLRED = CNT_W'(ALLRED_S);
    localparam logic [CNT_W-1:0] C_WALK   = CNT_W'(WALK_S);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
    localparam logic [6:0]       C_LED_ALLRED = 7'b010_0100;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             ret_ew_q, ret_ew_d;
    logic             ped_q, ped_d;
    logic [6:0]       leds_q, leds_d;
    logic             w_expire;

    function automatic logic [CNT_W-1:0] dur(input state_t s);
        case (s)
            ST_NS_GREEN, ST_EW_GREEN:   dur = C_GREEN;
            ST_NS_YELLOW, ST_EW_YELLOW: dur = C_YELLOW;
            ST_PED_WALK:                dur = C_WALK;
            default:                    dur = C_ALLRED;
        endcase
    endfunction

    // bits: {walk, EW r/y/g, NS r/y/g}
    function automatic logic [6:0] led_dec(input state_t s);
        case (s)
            ST_NS_GREEN:  led_dec = 7'b010_0001;
            ST_NS_YELLOW: led_dec = 7'b010_0010;
            ST_EW_GREEN:  led_dec = 7'b000_1100;
            ST_EW_YELLOW: led_dec = 7'b001_0100;
            ST_PED_WALK:  led_dec = 7'b110_0100;
            default:      led_dec = C_LED_ALLRED;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ALLRED_B;
            rem_q    <= C_ALLRED;
            ret_ew_q <= 1'b0;
            ped_q    <= 1'b0;
            leds_q   <= C_LED_ALLRED;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            ret_ew_q <= ret_ew_d;
            ped_q    <= ped_d;
            leds_q   <= leds_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        ret_ew_d = ret_ew_q;
        ped_d    = ped_q;
        w_expire = tick_1s && (rem_q <= C_ONE);

        case (state_q)
            ST_NS_GREEN:  if (w_expire) state_d = ST_NS_YELLOW;
            ST_NS_YELLOW: if (w_expire) state_d = ST_ALLRED_A;
            ST_ALLRED_A: begin
                if (w_expire) begin
                    ret_ew_d = 1'b1;
                    state_d  = ped_q ? ST_PED_WALK : ST_EW_GREEN;
                end
            end
            ST_EW_GREEN:  if (w_expire) state_d = ST_EW_YELLOW;
            ST_EW_YELLOW: if (w_expire) state_d = ST_ALLRED_B;
            ST_ALLRED_B: begin
                if (w_expire) begin
                    ret_ew_d = 1'b0;
                    state_d  = ped_q ? ST_PED_WALK : ST_NS_GREEN;
                end
            end
            ST_PED_WALK:  if (w_expire) state_d = ret_ew_q ? ST_EW_GREEN : ST_NS_GREEN;
            default:      state_d = ST_ALLRED_B;
        endcase

        // Every phase change (including recovery from code 7) reloads the counter
        if (state_d != state_q) begin
            rem_d = dur(state_d);
        end else if (tick_1s) begin
            rem_d = rem_q - C_ONE;
        end

        if (state_d == ST_PED_WALK && state_q != ST_PED_WALK) begin
            ped_d = 1'b0;
        end else if (ped_req && state_q != ST_PED_WALK) begin
            ped_d = 1'b1;
        end

        leds_d = led_dec(state_d);
    end

    assign leds      = {ped_q, leds_q};
    assign phase     = state_q;
    assign remaining = rem_q;

endmodule
`default_nettype wire
